// File: rtl/sram_rd_streamer.sv
// Read sequencer for a single-port SRAM: issues LEN wrapping reads from BASE and streams the
// returned words over valid/ready, with a credit-limited buffer covering the one-cycle read latency.
module sram_rd_streamer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [DATA_W-1:0] sram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W:0]    DEPTH_C  = (OCC_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   last_a_r;
    logic [ADDR_W:0]     remaining_r;
    logic                inflight_r;
    logic [OCC_W-1:0]    occ_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [DATA_W-1:0]   buf_r [DEPTH];
    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic [OCC_W:0]      credit_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_s    = out_valid & out_ready;
    assign push_s   = inflight_r;
    assign out_valid = (occ_r != {OCC_W{1'b0}});
    assign out_data  = buf_r[rd_ptr_r];
    assign busy      = (state_r == RUN) || (state_r == DRAIN);
    assign done      = (state_r == DONE);
    assign sram_wen  = 1'b1;
    assign sram_cen  = ~issue_s;
    assign sram_a    = issue_s ? addr_r : last_a_r;

    // Credit check: a read may be issued only if its word is guaranteed a buffer slot on return.
    always_comb begin
        credit_s = {1'b0, occ_r} + {{OCC_W{1'b0}}, inflight_r} - {{OCC_W{1'b0}}, pop_s};
        if (state_r == RUN) begin
            issue_s = (credit_s < DEPTH_C);
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic for the command sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (len == LEN_ZERO) ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && (remaining_r == LEN_ONE)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if ((occ_r == {OCC_W{1'b0}}) && !inflight_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, address/length counters and the last-driven SRAM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            last_a_r    <= {ADDR_W{1'b0}};
            remaining_r <= LEN_ZERO;
            inflight_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            inflight_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                addr_r      <= base_addr;
                remaining_r <= len;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_W'(1);
                remaining_r <= remaining_r - LEN_ONE;
                last_a_r    <= addr_r;
            end
        end
    end

    // Output buffer: capture returning SRAM words, release on downstream acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r    <= {OCC_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                buf_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                buf_r[wr_ptr_r] <= sram_q;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule
